// File: rtl/mul_controller.sv
// Sequencing FSM for the repeated-addition multiplier datapath (A reg, P accumulator, B down-counter).
// Optional build macro MUL_CTRL_CYCLE_CNT_EN adds the iter_count output (adds performed by the last finished op).
module mul_controller #(
    parameter int CNT_W    = 17,
    parameter int MAX_ITER = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic eqz,
    output logic op_sel,
    output logic ldA,
    output logic ldB,
    output logic ldP,
    output logic clrP,
    output logic decB,
    output logic busy,
    output logic done,
    output logic err
`ifdef MUL_CTRL_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] iter_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_A,
        S_LD_B,
        S_ADD,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ITER);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_sel    = 1'b0;
        ldA       = 1'b0;
        ldB       = 1'b0;
        ldP       = 1'b0;
        clrP      = 1'b0;
        decB      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        busy      = (state != S_IDLE);

        // Abort wins over everything and suppresses all strobes, leaving the datapath untouched.
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) state_nxt = S_LD_A;
                end
                S_LD_A: begin
                    ldA       = 1'b1;
                    op_sel    = 1'b0;
                    state_nxt = S_LD_B;
                end
                S_LD_B: begin
                    ldB       = 1'b1;
                    clrP      = 1'b1;
                    op_sel    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_ADD;
                end
                S_ADD: begin
                    if (eqz) begin
                        state_nxt = S_DONE;
                    end else if (cnt == CNT_MAX) begin
                        // Timeout check precedes the add, which also keeps cnt from ever passing CNT_MAX.
                        state_nxt = S_ERR;
                    end else begin
                        ldP     = 1'b1;
                        decB    = 1'b1;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
                S_ERR: begin
                    err       = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef MUL_CTRL_CYCLE_CNT_EN
    // Captured on entry to DONE/ERR; an aborted op never reaches either, so it leaves this untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_count <= '0;
        end else if (state_nxt == S_DONE || state_nxt == S_ERR) begin
            iter_count <= cnt;
        end
    end
`endif

endmodule

// File: tb/tb_mul_controller.sv
// Scoreboard bench for mul_controller: a behavioural datapath closes the loop, a negedge monitor
// compares each done/err against the expected outcome queued when the start was accepted.
module tb_mul_controller;

    localparam int CNT_W    = 17;
    localparam int MAX_ITER = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic eqz;
    logic op_sel, ldA, ldB, ldP, clrP, decB, busy, done, err;
`ifdef MUL_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0] iter_count;
`endif

    always #5 clk = ~clk;

    mul_controller #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .eqz    (eqz),
        .op_sel (op_sel),
        .ldA    (ldA),
        .ldB    (ldB),
        .ldP    (ldP),
        .clrP   (clrP),
        .decB   (decB),
        .busy   (busy),
        .done   (done),
        .err    (err)
`ifdef MUL_CTRL_CYCLE_CNT_EN
        ,
        .iter_count (iter_count)
`endif
    );

    // Behavioural datapath: operand bus, A register, B down-counter, P accumulator.
    logic [15:0] a_op = '0, b_op = '0;
    logic [15:0] a_reg = '0, b_reg = '0, p_reg = '0;
    logic        force_low = 1'b0;
    wire  [15:0] data_in = op_sel ? b_op : a_op;
    logic [8:0]  outs;

    assign eqz  = force_low ? 1'b0 : (b_reg == 16'd0);
    assign outs = {op_sel, ldA, ldB, ldP, clrP, decB, busy, done, err};

    always @(posedge clk) begin
        if (ldA) a_reg <= data_in;
        if (ldB) b_reg <= data_in;
        else if (decB) b_reg <= b_reg - 16'd1;
        if (clrP) p_reg <= '0;
        else if (ldP) p_reg <= p_reg + a_reg;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          is_err;
        logic [15:0] p;
        int          adds;
    } exp_t;

    exp_t sb[$];

    // Reference: B adds to reach zero, unless that exceeds the iteration limit or eqz is stuck low.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input bit stuck);
        exp_t e;
        if (!stuck && int'(b) <= MAX_ITER) begin
            e.is_err = 1'b0;
            e.p      = 16'((int'(a) * int'(b)) % 65536);
            e.adds   = int'(b);
        end else begin
            e.is_err = 1'b1;
            e.p      = '0;
            e.adds   = MAX_ITER;
        end
        return e;
    endfunction

    // Monitor: records accepted starts, retires aborted ops, and checks every completion.
    int adds_seen = 0;
    bit prev_end  = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            adds_seen = 0;
            prev_end  = 1'b0;
        end else begin
            if (prev_end) check("busy_after_end", busy, 0);
            prev_end = done | err;
            if (ldA) begin
                adds_seen = 0;
                check("ldA_op_sel", op_sel, 0);
            end
            if (ldB) begin
                check("ldB_op_sel", op_sel, 1);
                check("ldB_clrP", clrP, 1);
            end
            if (ldP) begin
                adds_seen++;
                check("ldP_with_decB", decB, 1);
            end
            if (start && !busy) sb.push_back(model(a_op, b_op, force_low));
            if (abort && busy && sb.size() > 0) void'(sb.pop_front());
            if (done || err) begin
                check("end_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("end_kind_err", err, e.is_err);
                    check("add_count", adds_seen, e.adds);
                    if (!e.is_err) check("product", p_reg, e.p);
`ifdef MUL_CTRL_CYCLE_CNT_EN
                    check("iter_count", iter_count, e.adds);
`endif
                end
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, output int t_lda);
        @(posedge clk); #1;
        a_op  = a;
        b_op  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t_lda = cyc;
    endtask

    task automatic wait_end(output int c);
        int k = 0;
        @(negedge clk);
        while (!(done || err) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("end_seen", (done || err), 1);
        c = cyc;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("returned_idle", busy, 0);
    endtask

    task automatic wait_adds(input int n);
        int seen = 0;
        int k = 0;
        while (seen < n && k < 50) begin
            @(negedge clk);
            if (ldP) seen++;
            k++;
        end
        check("adds_reached", seen, n);
    endtask

    // Latency counts LD_B, B adds, the eqz ADD cycle and DONE after LD_A: B + 3 cycles past LD_A.
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input int exp_lat);
        int t0, t1;
        issue(a, b, t0);
        wait_end(t1);
        check(name, t1 - t0, exp_lat);
        wait_idle();
    endtask

    initial begin
        int t0, d1, d2, d3;
        logic [15:0] ra, rb;

        repeat (2) @(negedge clk);
        check("reset_outputs", outs, 0);
`ifdef MUL_CTRL_CYCLE_CNT_EN
        check("reset_iter_count", iter_count, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run_op("lat_a7_b5", 16'd7, 16'd5, 8);
        run_op("lat_a9_b0", 16'd9, 16'd0, 3);
        run_op("lat_a0_b4", 16'd0, 16'd4, 7);

        // Abort in the second ADD cycle: no completion, idle next cycle.
        issue(16'd3, 16'd4, t0);
        wait_adds(1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_to_idle", busy, 0);
        check("abort_retired", sb.size(), 0);
        run_op("lat_after_abort", 16'd2, 16'd2, 5);

        // Stuck comparator times out after exactly MAX_ITER adds.
        force_low = 1'b1;
        run_op("lat_timeout", 16'd5, 16'd3, MAX_ITER + 3);
        force_low = 1'b0;
        run_op("lat_b_at_limit", 16'd1, 16'(MAX_ITER), MAX_ITER + 3);
        run_op("lat_b_over_limit", 16'd1, 16'(MAX_ITER + 1), MAX_ITER + 3);

        // Reset mid-ADD: outputs clear without waiting for a clock edge.
        issue(16'd5, 16'd7, t0);
        wait_adds(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_op("lat_after_reset", 16'd6, 16'd6, 9);

        // start held high: one idle cycle between back-to-back ops.
        @(posedge clk); #1;
        a_op  = 16'd2;
        b_op  = 16'd1;
        start = 1'b1;
        wait_end(d1);
        wait_end(d2);
        wait_end(d3);
        #1;
        start = 1'b0;
        check("held_start_period_1", d2 - d1, 6);
        check("held_start_period_2", d3 - d2, 6);
        wait_idle();

        // Random operands, with a stray start pulse while busy that must be ignored.
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom_range(0, MAX_ITER + 4));
            issue(ra, rb, t0);
            if ($urandom_range(0, 1) == 1) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            wait_idle();
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
